rr_hold_arbiter: RTL and testbench

- Round-robin arbiter sharing one bus/resource between N requesters.
- Generalises the fixed-priority 3-way grant FSM. Fairness comes from a rotating priority pointer.
- A hold-time limit forcibly releases a requester that keeps the resource while others wait.
- Sits between requester blocks and the shared datapath. Its grant drives the datapath mux select.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_hold_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 31 +++
 rtl/rr_hold_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_hold_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package arb_pkg;

  // Widest requester vector any instance may use.
  localparam int unsigned MaxN = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StGrant   = 2'b01,
    StRelease = 2'b10
  } arb_state_e;

  // One-hot vector with bit idx set; all zero when idx is outside 0..n-1.
  function automatic logic [MaxN-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MaxN-1:0] r;
    r = MaxN'(1) << idx;
    if (idx >= n) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/rr_hold_arbiter_if.sv
// Requester-side bus of the round-robin hold arbiter.
interface rr_hold_arbiter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempt;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output preempt
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    any = |req;
    dbl = {req, req};
    rot = dbl[ptr +: N];
    off = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a hold-time limit and a one-cycle turnaround between owners.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic         Clock,
  input logic         Resetn,
  rr_hold_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HoldMax = HCW'(MAX_HOLD - 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [MaxN-1:0] pick_oh_full;
  logic [N-1:0]    pick_oh;
  logic            owner_req;
  logic            others_req;
  logic [IDW-1:0]  ptr_next;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_oh_full = onehot(32'(pick_idx), N);
  assign pick_oh      = pick_oh_full[N-1:0];
  // grant_q is the owner's one-hot while in StGrant.
  assign owner_req    = |(bus.req & grant_q);
  assign others_req   = |(bus.req & ~grant_q);
  assign ptr_next     = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;

  // Next-state, grant and bookkeeping decisions.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      StIdle, StRelease: begin
        if (pick_any) begin
          state_d    = StGrant;
          grant_d    = pick_oh;
          grant_id_d = pick_idx;
          hold_d     = '0;
        end else begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          state_d = StRelease;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (hold_q == HoldMax && others_req) begin
          state_d   = StRelease;
          grant_d   = '0;
          ptr_d     = ptr_next;
          preempt_d = 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    grant_valid_d = |grant_d;
  end

  // State and registered outputs; reset is asynchronous so it clears mid-grant.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      preempt_q     <= 1'b0;
      ptr_q         <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      preempt_q     <= preempt_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter with N=4, MAX_HOLD=4.
module tb_rr_hold_arbiter;

  logic Clock;
  logic Resetn;
  int   errors;
  int   checks;

  rr_hold_arbiter_if #(.N(4)) bus ();

  rr_hold_arbiter #(
    .N        (4),
    .MAX_HOLD (4)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    Resetn  = 1'b0;
    #3;
    Resetn  = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.req = '0;
    Resetn  = 1'b0;
    #7;
    checks++;
    if (bus.grant !== 4'b0000) begin
      errors++; $display("FAIL reset grant: got %b want 0000", bus.grant);
    end
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      errors++; $display("FAIL reset grant_valid: got %b want 0", bus.grant_valid);
    end
    checks++;
    if (bus.grant_id !== 2'd0) begin
      errors++; $display("FAIL reset grant_id: got %0d want 0", bus.grant_id);
    end
    checks++;
    if (bus.preempt !== 1'b0) begin
      errors++; $display("FAIL reset preempt: got %b want 0", bus.preempt);
    end
    Resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
        errors++;
        $display("FAIL single grant cycle %0d: got %b/%b/%0d want 0001/1/0", c, bus.grant,
                 bus.grant_valid, bus.grant_id);
      end
    end
    bus.req = 4'b0000;
    step();
    checks++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.preempt !== 1'b0) begin
      errors++;
      $display("FAIL single release: got %b/%b/%b want 0000/0/0", bus.grant, bus.grant_valid,
               bus.preempt);
    end
    step();
    checks++;
    if (bus.grant !== 4'b0000 || bus.grant_id !== 2'd0) begin
      errors++; $display("FAIL single idle: got %b id %0d want 0000 id 0", bus.grant, bus.grant_id);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_grant;
    logic       exp_pre;
    do_reset();
    bus.req = 4'b1111;
    for (int c = 1; c <= 30; c++) begin
      step();
      // Four grant cycles per owner, then one preempted turnaround cycle.
      if ((c - 1) % 5 < 4) begin
        exp_grant = 4'b0001 << (((c - 1) / 5) % 4);
        exp_pre   = 1'b0;
      end else begin
        exp_grant = 4'b0000;
        exp_pre   = 1'b1;
      end
      checks++;
      if (bus.grant !== exp_grant) begin
        errors++; $display("FAIL contention grant cycle %0d: got %b want %b", c, bus.grant, exp_grant);
      end
      checks++;
      if (bus.preempt !== exp_pre) begin
        errors++; $display("FAIL contention preempt cycle %0d: got %b want %b", c, bus.preempt, exp_pre);
      end
      checks++;
      if ($countones(bus.grant) > 1) begin
        errors++; $display("FAIL contention onehot cycle %0d: got %b want <=1 bit", c, bus.grant);
      end
    end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_lone();
    do_reset();
    bus.req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (bus.grant !== 4'b0100 || bus.preempt !== 1'b0) begin
        errors++;
        $display("FAIL lone cycle %0d: got %b pre %b want 0100 pre 0", c, bus.grant, bus.preempt);
      end
    end
    bus.req = 4'b0101;
    step();
    checks++;
    if (bus.grant !== 4'b0000 || bus.preempt !== 1'b1) begin
      errors++; $display("FAIL lone preempt: got %b pre %b want 0000 pre 1", bus.grant, bus.preempt);
    end
    step();
    checks++;
    if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0 || bus.preempt !== 1'b0) begin
      errors++;
      $display("FAIL lone next owner: got %b id %0d pre %b want 0001 id 0 pre 0", bus.grant,
               bus.grant_id, bus.preempt);
    end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000;
    step();
    checks++;
    if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3) begin
      errors++; $display("FAIL wrap owner: got %b id %0d want 1000 id 3", bus.grant, bus.grant_id);
    end
    bus.req = 4'b1011;
    step();
    bus.req = 4'b0011;
    step();
    checks++;
    if (bus.grant !== 4'b0000 || bus.preempt !== 1'b0) begin
      errors++; $display("FAIL wrap release: got %b pre %b want 0000 pre 0", bus.grant, bus.preempt);
    end
    step();
    checks++;
    if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
      errors++; $display("FAIL wrap next: got %b id %0d want 0001 id 0", bus.grant, bus.grant_id);
    end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0010;
    step();
    checks++;
    if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
      errors++; $display("FAIL async pre-reset: got %b id %0d want 0010 id 1", bus.grant, bus.grant_id);
    end
    #2;
    Resetn = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 4'b0000 || bus.grant_id !== 2'd0 || bus.preempt !== 1'b0 ||
        bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL async reset: got %b id %0d pre %b v %b want 0000 id 0 pre 0 v 0", bus.grant,
               bus.grant_id, bus.preempt, bus.grant_valid);
    end
    bus.req = 4'b1111;
    #1;
    Resetn = 1'b1;
    step();
    checks++;
    if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
      errors++; $display("FAIL async first grant: got %b id %0d want 0001 id 0", bus.grant, bus.grant_id);
    end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_drop_and_new();
    do_reset();
    bus.req = 4'b0010;
    step();
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++; $display("FAIL swap owner: got %b want 0010", bus.grant);
    end
    bus.req = 4'b0100;
    step();
    checks++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.preempt !== 1'b0) begin
      errors++;
      $display("FAIL swap release: got %b v %b pre %b want 0000 v 0 pre 0", bus.grant,
               bus.grant_valid, bus.preempt);
    end
    step();
    checks++;
    if (bus.grant !== 4'b0100 || bus.grant_id !== 2'd2 || bus.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL swap next: got %b id %0d v %b want 0100 id 2 v 1", bus.grant, bus.grant_id,
               bus.grant_valid);
    end
    bus.req = '0;
    step();
    step();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    bus.req = '0;
    Resetn  = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_lone();
    test_wrap();
    test_async_reset();
    test_drop_and_new();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
